mem_rsp_router: RTL and testbench

- Return-path counterpart of the shared-memory request mux. Fetch (IF) and data (MEM) stages share one memory port; this block returns each read response to the stage that issued it.
- Records the requester of every issued request in an in-order tag FIFO.
- On each memory response it pops one tag and drives a registered valid/data pair to IF or MEM.
- Supports flushing in-flight fetch responses on a pipeline redirect.

---
 rtl/mem_rsp_router_pkg.sv | 17 +
 rtl/mem_rsp_router_tag_fifo.sv | 78 +++++++
 rtl/mem_rsp_router.sv | 89 ++++++++
 tb/tb_mem_rsp_router.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rsp_router_pkg.sv
// rtl/mem_rsp_router_pkg.sv - tag format and select constants for mem_rsp_router
// Contents:
//   SEL_INST / SEL_DATA : requester encodings stored in each tag
//   DEFAULT_N           : default response data width
//   tag_t               : one tag FIFO entry, {sel, drop}
package mem_rsp_router_pkg;

  localparam logic SEL_INST  = 1'b0;
  localparam logic SEL_DATA  = 1'b1;
  localparam int   DEFAULT_N = 32;

  typedef struct packed {
    logic sel;
    logic drop;
  } tag_t;

endpackage

// File: rtl/mem_rsp_router_tag_fifo.sv
// rtl/mem_rsp_router_tag_fifo.sv - in-order {sel, drop} tag FIFO with flush marking
// Module rsp_tag_fifo
//   clk, rst_n : clock, synchronous active-low reset
//   push       : record a request (ignored when full)
//   push_sel   : requester of the pushed request
//   pop        : consume the oldest tag (ignored when empty)
//   flush      : mark every occupied instruction tag as dropped
//   pop_tag    : tag at the read pointer (valid when !empty)
//   full/empty : occupancy flags
module rsp_tag_fifo
  import mem_rsp_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_sel,
  input  logic pop,
  input  logic flush,
  output tag_t pop_tag,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;
  logic [DEPTH-1:0] occ;
  logic [AW-1:0] off;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push at full is dropped even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_tag = mem[rd_ptr];

  // Slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    occ = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = AW'(i) - rd_ptr;
      occ[i] = ({1'b0, off} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // The slot being pushed is never occupied, so the fresh entry stays unmarked.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && occ[i] && (mem[i].sel == SEL_INST)) mem[i].drop <= 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= '{sel: push_sel, drop: 1'b0};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_rsp_router.sv
// rtl/mem_rsp_router.sv - routes in-order memory read responses back to IF or MEM
// Optional feature macro: MEM_RSP_ROUTER_ERR_EN (adds sticky err output)
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid, req_sel    : request issued this cycle and its requester (0 inst, 1 data)
//   req_ready             : tag FIFO has room
//   rsp_valid, rsp_data   : memory response, in issue order
//   flush                 : discard all outstanding instruction responses
//   inst_valid, inst_data : registered fetch delivery pulse and last fetch word
//   data_valid, data_rdata: registered load delivery pulse and last load word
//   err (optional)        : sticky protocol violation flag
module mem_rsp_router
  import mem_rsp_router_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic         req_sel,
  output logic         req_ready,
  input  logic         rsp_valid,
  input  logic [N-1:0] rsp_data,
  input  logic         flush,
  output logic         inst_valid,
  output logic [N-1:0] inst_data,
  output logic         data_valid,
  output logic [N-1:0] data_rdata
`ifdef MEM_RSP_ROUTER_ERR_EN
  ,
  output logic         err
`endif
);

  tag_t pop_tag;
  logic full;
  logic empty;
  logic pop_ok;

  rsp_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_valid),
    .push_sel (req_sel),
    .pop      (rsp_valid),
    .flush    (flush),
    .pop_tag  (pop_tag),
    .full     (full),
    .empty    (empty)
  );

  assign req_ready = !full;
  // A response arriving with no outstanding tag has no owner and is discarded.
  assign pop_ok    = rsp_valid && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst_data  <= '0;
      data_valid <= 1'b0;
      data_rdata <= '0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      if (pop_ok) begin
        if (pop_tag.sel == SEL_DATA) begin
          data_rdata <= rsp_data;
          data_valid <= 1'b1;
        end else if (!pop_tag.drop && !flush) begin
          // A flush in the pop cycle kills the response before its mark could land.
          inst_data  <= rsp_data;
          inst_valid <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_RSP_ROUTER_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((rsp_valid && empty) || (req_valid && full)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rsp_router.sv
// tb/tb_mem_rsp_router.sv - scoreboard bench for mem_rsp_router
module tb_mem_rsp_router;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_sel = 1'b0;
  logic        req_ready;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        data_valid;
  logic [31:0] data_rdata;
`ifdef MEM_RSP_ROUTER_ERR_EN
  logic        err;
`endif

  mem_rsp_router #(.N(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .data_valid (data_valid),
    .data_rdata (data_rdata)
`ifdef MEM_RSP_ROUTER_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic sel;
    logic drop;
  } mtag_t;

  typedef struct {
    logic        sel;
    logic [31:0] data;
    int          due;
  } exp_t;

  mtag_t       mq[$];
  exp_t        expq[$];
  logic [31:0] last_inst = '0;
  logic [31:0] last_data = '0;
  logic        err_exp = 1'b0;
  logic        done = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // One cycle of stimulus, applied at the falling edge; the model advances to the
  // state expected right after the following rising edge.
  task automatic step(input logic rv, input logic rs, input logic pv,
                      input logic [31:0] pd, input logic fl);
    int    n;
    mtag_t t;
    @(negedge clk);
    rst_n = 1'b1; req_valid = rv; req_sel = rs; rsp_valid = pv; rsp_data = pd; flush = fl;
    n = mq.size();
    if ((pv && n == 0) || (rv && n == DEPTH)) err_exp = 1'b1;
    if (pv && n > 0) begin
      t = mq.pop_front();
      if (t.sel) begin
        last_data = pd;
        expq.push_back('{1'b1, pd, cyc + 1});
      end else if (!t.drop && !fl) begin
        last_inst = pd;
        expq.push_back('{1'b0, pd, cyc + 1});
      end
    end
    if (fl) foreach (mq[i]) if (!mq[i].sel) mq[i].drop = 1'b1;
    if (rv && n < DEPTH) mq.push_back('{rs, 1'b0});
  endtask

  task automatic do_reset(input logic pv);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b1; req_sel = 1'b0; rsp_valid = pv; rsp_data = 32'hDEAD; flush = 1'b0;
    mq.delete();
    expq.delete();
    last_inst = '0;
    last_data = '0;
    err_exp   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      while (expq.size() > 0 && expq[0].due < cyc) begin
        e = expq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_pulse actual=none required=sel%0d:%h cycle=%0d", e.sel, e.data, cyc);
      end
      if (inst_valid || data_valid) begin
        if (expq.size() == 0 || expq[0].due != cyc) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=inst%0d/data%0d required=none cycle=%0d",
                   inst_valid, data_valid, cyc);
        end else begin
          e = expq.pop_front();
          chk("inst_valid", {31'b0, inst_valid}, {31'b0, e.sel == 1'b0});
          chk("data_valid", {31'b0, data_valid}, {31'b0, e.sel == 1'b1});
        end
      end
      chk("inst_data", inst_data, last_inst);
      chk("data_rdata", data_rdata, last_data);
      chk("req_ready", {31'b0, req_ready}, {31'b0, mq.size() != DEPTH});
`ifdef MEM_RSP_ROUTER_ERR_EN
      chk("err", {31'b0, err}, {31'b0, err_exp});
`endif
    end
    chk("pending_at_end", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    do_reset(1'b0);
    do_reset(1'b1);

    // Mixed ordering: inst, data, inst then back-to-back responses.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    step(0, 0, 1, 32'hC, 0);
    idle(2);

    // Fill to DEPTH, push at full, pop+push at full, then drain.
    for (int i = 0; i < DEPTH; i++) step(1, i[0], 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h100, 0);
    step(1, 0, 1, 32'h101, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'h200 + i, 0);
    idle(2);

    // Flush drops both outstanding fetches; only the load is delivered.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h1, 0);
    step(0, 0, 1, 32'h2, 0);
    step(0, 0, 1, 32'h3, 0);
    idle(2);

    // A fetch pushed in the flush cycle survives.
    step(1, 0, 0, 0, 1);
    step(0, 0, 1, 32'h55, 0);
    idle(2);

    // Flush coinciding with an inst pop kills it; with a data pop it does not.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 32'h66, 1);
    step(0, 0, 1, 32'h77, 1);
    idle(1);

    // Response with nothing outstanding.
    step(0, 0, 1, 32'h99, 0);
    idle(3);

    // Reset with three outstanding, then three orphan responses.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    do_reset(1'b0);
    step(0, 0, 1, 32'hE1, 0);
    step(0, 0, 1, 32'hE2, 0);
    step(0, 0, 1, 32'hE3, 0);
    do_reset(1'b0);

    // Randomized traffic, including occasional resets and protocol violations.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 11) == 0));
      end
    end
    idle(3);
    done = 1'b1;
    idle(2);
  end

endmodule
